// File: rtl/cordic_iter.sv
// Iterative CORDIC: one shift-add stage reused ITERS cycles, rotation or vectoring mode.
// Latency ITERS+1 cycles (ITERS+2 with CORDIC_GAIN_COMP_EN); Start_i ignored while busy/done.
module cordic_iter #(
  parameter int WIDTH = 16,
  parameter int ITERS = 16
) (
  input  logic                    Clk_i,
  input  logic                    Rst_i,
  input  logic                    Start_i,
  input  logic                    Mode_i,
  input  logic signed [WIDTH-1:0] X_i,
  input  logic signed [WIDTH-1:0] Y_i,
  input  logic signed [WIDTH-1:0] Z_i,
  output logic signed [WIDTH-1:0] X_o,
  output logic signed [WIDTH-1:0] Y_o,
  output logic signed [WIDTH-1:0] Z_o,
  output logic                    Busy_o,
  output logic                    Done_o
);

  localparam int XW = WIDTH + 2;
  localparam int CW = $clog2(ITERS);
  localparam logic [63:0] PI_Q40 = 64'h0000_0324_3F6A_8886;

  // atan(2^-i) scaled to angle LSBs, from an integer Taylor series evaluated at elaboration
  function automatic logic [WIDTH-1:0] atan_lsb(input int i);
    logic [63:0] p;
    logic [63:0] acc;
    logic [63:0] num;
    if (i == 0) return WIDTH'(64'd1 << (WIDTH - 3));
    acc = '0;
    p   = (64'd1 << 40) >> i;
    for (int k = 0; k < 32; k++) begin
      if (k[0]) acc = acc - p / 64'(2 * k + 1);
      else      acc = acc + p / 64'(2 * k + 1);
      p = p >> (2 * i);
    end
    num = ((acc << (WIDTH - 1)) << 1) + PI_Q40;
    return WIDTH'(num / (PI_Q40 << 1));
  endfunction

  function automatic logic [ITERS*WIDTH-1:0] atan_table();
    logic [ITERS*WIDTH-1:0] t;
    t = '0;
    for (int i = 0; i < ITERS; i++) t[i*WIDTH +: WIDTH] = atan_lsb(i);
    return t;
  endfunction

  localparam logic [ITERS*WIDTH-1:0] ATAN_TBL = atan_table();

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [XW-1:0] v);
    if (v[XW-1:WIDTH-1] == {3{v[XW-1]}}) return v[WIDTH-1:0];
    else if (v[XW-1])                   return {1'b1, {(WIDTH-1){1'b0}}};
    else                                return {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_COMP, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    mode_q, mode_d;
  logic signed [XW-1:0]    x_q, x_d, y_q, y_d;
  logic signed [WIDTH-1:0] z_q, z_d;
  logic signed [WIDTH-1:0] xo_q, xo_d, yo_q, yo_d, zo_q, zo_d;

  logic                    dir_pos;
  logic [WIDTH-1:0]        atan_cur;
  logic signed [XW-1:0]    x_sh, y_sh, x_step, y_step;
  logic signed [WIDTH-1:0] z_step;

  always_comb begin
    atan_cur = ATAN_TBL[cnt_q*WIDTH +: WIDTH];
    dir_pos  = mode_q ? y_q[XW-1] : ~z_q[WIDTH-1];
    x_sh     = x_q >>> cnt_q;
    y_sh     = y_q >>> cnt_q;
    x_step   = dir_pos ? (x_q - y_sh) : (x_q + y_sh);
    y_step   = dir_pos ? (y_q + x_sh) : (y_q - x_sh);
    z_step   = dir_pos ? (z_q - atan_cur) : (z_q + atan_cur);
  end

`ifdef CORDIC_GAIN_COMP_EN
  localparam int PW = XW + WIDTH + 1;
  localparam logic [WIDTH-1:0] K_GAIN =
    WIDTH'((64'd607252935 * (64'd1 << (WIDTH - 1)) + 64'd500000000) / 64'd1000000000);
  localparam logic signed [PW-1:0] K_EXT = PW'({1'b0, K_GAIN});
  localparam logic signed [PW-1:0] HALF  = PW'(1) << (WIDTH - 2);

  logic signed [PW-1:0] px, py, pxr, pyr;
  logic signed [XW-1:0] xc, yc;

  // |x*K| < 2^(WIDTH+1) after the shift, so truncating to XW bits keeps the value exact
  always_comb begin
    px  = PW'(x_q) * K_EXT;
    py  = PW'(y_q) * K_EXT;
    pxr = (px + HALF) >>> (WIDTH - 1);
    pyr = (py + HALF) >>> (WIDTH - 1);
    xc  = pxr[XW-1:0];
    yc  = pyr[XW-1:0];
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    xo_d    = xo_q;
    yo_d    = yo_q;
    zo_d    = zo_q;
    case (state_q)
      S_IDLE: begin
        if (Start_i) begin
          x_d     = XW'(X_i);
          y_d     = XW'(Y_i);
          z_d     = Z_i;
          mode_d  = Mode_i;
          cnt_d   = '0;
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        x_d   = x_step;
        y_d   = y_step;
        z_d   = z_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(ITERS - 1)) begin
`ifdef CORDIC_GAIN_COMP_EN
          state_d = S_COMP;
`else
          state_d = S_DONE;
          xo_d    = sat(x_step);
          yo_d    = sat(y_step);
          zo_d    = z_step;
`endif
        end
      end
`ifdef CORDIC_GAIN_COMP_EN
      S_COMP: begin
        state_d = S_DONE;
        xo_d    = sat(xc);
        yo_d    = sat(yc);
        zo_d    = z_q;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      xo_q    <= '0;
      yo_q    <= '0;
      zo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      xo_q    <= xo_d;
      yo_q    <= yo_d;
      zo_q    <= zo_d;
    end
  end

  assign X_o    = xo_q;
  assign Y_o    = yo_q;
  assign Z_o    = zo_q;
  assign Busy_o = (state_q == S_ITER) || (state_q == S_COMP);
  assign Done_o = (state_q == S_DONE);

endmodule
